cpsr_ctrl: RTL



---
 rtl/cpsr_ctrl_pkg.sv | 31 +++
 rtl/cpsr_ctrl_if.sv | 29 ++
 rtl/cpsr_ctrl_cond_eval.sv | 36 +++
 rtl/cpsr_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/cpsr_ctrl_pkg.sv
// Shared definitions for the CPSR write controller: bit positions, condition
// encodings, reset word and controller state encodings.
package cpsr_ctrl_pkg;

    localparam int CPSR_FULLW = 32;
    localparam int CPSR_BYTEW = 8;
    localparam logic [31:0] RESET_CPSR_DEFAULT = 32'h0000_00D3;

    localparam int CPSR_N       = 31;
    localparam int CPSR_Z       = 30;
    localparam int CPSR_C       = 29;
    localparam int CPSR_V       = 28;
    localparam int CPSR_I       = 7;
    localparam int CPSR_F       = 6;
    localparam int CPSR_MODE_HI = 4;
    localparam int CPSR_MODE_LO = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

endpackage

// File: rtl/cpsr_ctrl_if.sv
// Bundle between the CPSR controller, the execute stage and the CPSR register.
// The master side is the controller; the slave side is its environment.
interface cpsr_ctrl_if #(
    parameter int FULLW = 32
) ();
    logic             flag_we;
    logic [3:0]       flags_in;
    logic             msr_we;
    logic [3:0]       msr_mask;
    logic [FULLW-1:0] msr_data;
    logic [3:0]       cond;
    logic             cond_pass;
    logic             ready;
    logic             mode_chg;
    logic             reg_we;
    logic [FULLW-1:0] reg_d;
    logic [FULLW-1:0] reg_q;
    logic [FULLW-1:0] cpsr;

    modport master (
        input  flag_we, flags_in, msr_we, msr_mask, msr_data, cond, reg_q,
        output cond_pass, ready, mode_chg, reg_we, reg_d, cpsr
    );

    modport slave (
        output flag_we, flags_in, msr_we, msr_mask, msr_data, cond, reg_q,
        input  cond_pass, ready, mode_chg, reg_we, reg_d, cpsr
    );
endinterface

// File: rtl/cpsr_ctrl_cond_eval.sv
// ARM condition-code evaluator: purely combinational (cond, NZCV) -> pass.
// Kept standalone so the decode stage can instantiate the same table.
module cpsr_ctrl_cond_eval
    import cpsr_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_pass
);
    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = i_nzcv;

    always_comb begin
        o_pass = 1'b0;
        case (cond_e'(i_cond))
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = w_z || (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpsr_ctrl.sv
// CPSR write-side controller: initialises the register after reset, merges
// MSR/flag updates into read-modify-write words and evaluates conditions.
module cpsr_ctrl
    import cpsr_ctrl_pkg::*;
#(
    parameter int               FULLW      = CPSR_FULLW,
    parameter int               BYTEW      = CPSR_BYTEW,
    parameter logic [FULLW-1:0] RESET_CPSR = RESET_CPSR_DEFAULT,
    parameter int               FWD        = 0
) (
    input  logic        clk,
    input  logic        reset,
    cpsr_ctrl_if.master bus
);
    localparam int NBYTES = FULLW / BYTEW;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_mode_chg;
    logic             w_reg_we;
    logic [FULLW-1:0] w_reg_d;
    logic             w_ready;
    logic [FULLW-1:0] w_msr_word;
    logic [FULLW-1:0] w_wr_word;
    logic [3:0]       w_nzcv;
    logic             w_cond_ok;

    // Byte-wise MSR field merge over the current register contents.
    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_msr_merge
            assign w_msr_word[gi*BYTEW +: BYTEW] =
                (bus.msr_we && bus.msr_mask[gi]) ? bus.msr_data[gi*BYTEW +: BYTEW]
                                                 : bus.reg_q[gi*BYTEW +: BYTEW];
        end
    endgenerate

    // Flags land last so they win over an MSR f-field write in the same cycle.
    assign w_wr_word = bus.flag_we ? {bus.flags_in, w_msr_word[CPSR_N-4:0]} : w_msr_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Reset is honoured combinationally too, so a write issued in the reset
    // cycle never reaches the register.
    always_comb begin
        w_state_next = r_state;
        w_reg_we     = 1'b0;
        w_reg_d      = bus.reg_q;
        w_ready      = 1'b0;
        if (reset) begin
            w_state_next = ST_INIT;
            w_reg_we     = 1'b1;
            w_reg_d      = RESET_CPSR;
        end else begin
            case (r_state)
                ST_INIT: begin
                    w_reg_we     = 1'b1;
                    w_reg_d      = RESET_CPSR;
                    w_state_next = ST_SETTLE;
                end
                ST_SETTLE: begin
                    w_state_next = ST_RUN;
                end
                ST_RUN: begin
                    w_ready  = 1'b1;
                    w_reg_we = bus.flag_we || bus.msr_we;
                    w_reg_d  = w_wr_word;
                end
                default: begin
                    w_state_next = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode_chg <= 1'b0;
        end else begin
            r_mode_chg <= w_ready && w_reg_we &&
                          (w_reg_d[CPSR_MODE_HI:CPSR_MODE_LO] != bus.reg_q[CPSR_MODE_HI:CPSR_MODE_LO]);
        end
    end

    assign w_nzcv = ((FWD != 0) && w_ready && w_reg_we) ? w_reg_d[CPSR_N -: 4]
                                                          : bus.reg_q[CPSR_N -: 4];

    cpsr_ctrl_cond_eval u_cond_eval (
        .i_cond (bus.cond),
        .i_nzcv (w_nzcv),
        .o_pass (w_cond_ok)
    );

    assign bus.cond_pass = w_ready && w_cond_ok;
    assign bus.ready     = w_ready;
    assign bus.mode_chg  = r_mode_chg;
    assign bus.reg_we    = w_reg_we;
    assign bus.reg_d     = w_reg_d;
    assign bus.cpsr      = w_ready ? bus.reg_q : RESET_CPSR;
endmodule
